// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory stage with request/ack FSM, timeout abort and MEM/WB register.
module mem_wb_stage #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        WEN_M,
  input  logic        DRW_M,
  input  logic        DREQ_M,
  input  logic [1:0]  SelWB_M,
  input  logic [4:0]  WA_M,
  input  logic [31:0] PCADD4_M,
  input  logic [31:0] ALUOUT_M,
  input  logic [31:0] DOUT0_M,
  output logic        D_REQ_N,
  output logic        D_RW,
  output logic [31:0] D_ADDR,
  output logic [31:0] D_WDATA,
  input  logic        D_ACK,
  input  logic [31:0] D_RDATA,
  output logic        STALL_M,
  output logic        ERR,
  output logic        WEN_W,
  output logic [4:0]  WA_W,
  output logic [31:0] WBDATA_W
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic stall, commit, abort;
  logic [31:0] wb;
  assign D_REQ_N = !RSTN | DREQ_M;
  assign STALL_M = RSTN & stall;
  assign D_RW    = DRW_M;
  assign D_ADDR  = ALUOUT_M;
  assign D_WDATA = DOUT0_M;
  always_comb
    wb = SelWB_M == 2'd0 ? ALUOUT_M : SelWB_M == 2'd1 ? D_RDATA : SelWB_M == 2'd2 ? PCADD4_M : 32'h0;
  // In WAIT the request is held by the frozen upstream, so DREQ_M is not re-examined
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    if (state == IDLE) begin
      if (DREQ_M || D_ACK) commit = 1'b1;
      else begin
        stall   = 1'b1;
        cnt_n   = CNT_W'(1);
        state_n = WAIT;
      end
    end else if (D_ACK) begin
      commit  = 1'b1;
      cnt_n   = '0;
      state_n = IDLE;
    end else if (cnt < CNT_W'(MAX_WAIT - 1)) begin
      stall = 1'b1;
      cnt_n = cnt + 1'b1;
    end else begin
      abort   = 1'b1;
      cnt_n   = '0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state    <= IDLE;
      cnt      <= '0;
      ERR      <= 1'b0;
      WEN_W    <= 1'b1;
      WA_W     <= '0;
      WBDATA_W <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ERR      <= ERR | abort;
      WEN_W    <= commit ? WEN_M : 1'b1;
      WA_W     <= commit ? WA_M : 5'd0;
      WBDATA_W <= commit ? wb : 32'h0;
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: transaction-level random bench; each op gets an ack delay and the expected stall/write-back follows.
module tb_mem_wb_stage;
  localparam int MAX_WAIT = 8;
  logic CLK = 1'b0, RSTN;
  logic WEN_M, DRW_M, DREQ_M, D_ACK;
  logic [1:0] SelWB_M;
  logic [4:0] WA_M;
  logic [31:0] PCADD4_M, ALUOUT_M, DOUT0_M, D_RDATA;
  logic D_REQ_N, D_RW, STALL_M, ERR, WEN_W;
  logic [31:0] D_ADDR, D_WDATA, WBDATA_W;
  logic [4:0] WA_W;
  int checks = 0, failures = 0;
  bit exp_err = 0;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .WEN_M(WEN_M), .DRW_M(DRW_M), .DREQ_M(DREQ_M),
    .SelWB_M(SelWB_M), .WA_M(WA_M), .PCADD4_M(PCADD4_M), .ALUOUT_M(ALUOUT_M),
    .DOUT0_M(DOUT0_M), .D_REQ_N(D_REQ_N), .D_RW(D_RW), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_ACK(D_ACK), .D_RDATA(D_RDATA), .STALL_M(STALL_M),
    .ERR(ERR), .WEN_W(WEN_W), .WA_W(WA_W), .WBDATA_W(WBDATA_W)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_of(input logic [1:0] sel, input logic [31:0] alu, rd, pc);
    return sel == 2'd0 ? alu : sel == 2'd1 ? rd : sel == 2'd2 ? pc : 32'h0;
  endfunction

  // k = cycle index on which memory acks; k >= MAX_WAIT means never
  task automatic run_op(input logic wen, drw, dreq, input logic [1:0] sel, input logic [4:0] wa,
                        input logic [31:0] pc, alu, dout, rdata, input int k);
    int n;
    bit ok;
    n  = dreq ? 1 : (k < MAX_WAIT ? k + 1 : MAX_WAIT);
    ok = dreq || k < MAX_WAIT;
    WEN_M = wen; DRW_M = drw; DREQ_M = dreq; SelWB_M = sel; WA_M = wa;
    PCADD4_M = pc; ALUOUT_M = alu; DOUT0_M = dout;
    for (int i = 0; i < n; i++) begin
      D_ACK   = dreq ? 1'($urandom_range(0, 1)) : (i == k);
      D_RDATA = (i == n - 1) ? rdata : $urandom;
      @(negedge CLK);
      chk("stall", STALL_M, i < n - 1);
      chk("req_n", D_REQ_N, dreq);
      chk("addr", D_ADDR, alu);
      chk("wdata", D_WDATA, dout);
      chk("rw", D_RW, drw);
      @(posedge CLK); #1;
      if (i == n - 1 && !ok) exp_err = 1;
      if (i < n - 1 || !ok) begin
        chk("wen_bub", WEN_W, 1);
        chk("wa_bub", WA_W, 0);
        chk("data_bub", WBDATA_W, 0);
      end else begin
        chk("wen", WEN_W, wen);
        chk("wa", WA_W, wa);
        chk("data", WBDATA_W, wb_of(sel, alu, rdata, pc));
      end
      chk("err", ERR, exp_err);
    end
  endtask

  initial begin
    RSTN = 0; WEN_M = 0; DRW_M = 0; DREQ_M = 0; SelWB_M = 0; WA_M = 7;
    PCADD4_M = 1; ALUOUT_M = 2; DOUT0_M = 3; D_ACK = 0; D_RDATA = 4;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wen", WEN_W, 1); chk("rst_wa", WA_W, 0); chk("rst_data", WBDATA_W, 0);
    chk("rst_err", ERR, 0); chk("rst_req_n", D_REQ_N, 1); chk("rst_stall", STALL_M, 0);
    DREQ_M = 1;
    @(negedge CLK) RSTN = 1;
    @(posedge CLK); #1;
    run_op(0, 0, 1, 2'd0, 5'd5, 32'h0, 32'h1234, 32'h0, 32'h0, 0);
    run_op(0, 0, 0, 2'd1, 5'd3, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF, 0);
    run_op(0, 0, 0, 2'd1, 5'd9, 32'h0, 32'h80, 32'h0, 32'hCAFEF00D, 3);
    run_op(1, 1, 0, 2'd0, 5'd0, 32'h0, 32'h100, 32'hA5A5A5A5, 32'h0, 99);
    run_op(0, 0, 1, 2'd0, 5'd6, 32'h0, 32'h777, 32'h0, 32'h0, 0);
    run_op(0, 0, 1, 2'd2, 5'd31, 32'h104, 32'h0, 32'h0, 32'h0, 0);
    run_op(0, 0, 0, 2'd1, 5'd4, 32'h0, 32'h44, 32'h0, 32'h12345678, 0);
    run_op(0, 0, 0, 2'd1, 5'd8, 32'h0, 32'h48, 32'h0, 32'h0BADF00D, MAX_WAIT - 1);
    for (int t = 0; t < 60; t++)
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 10));
    // asynchronous reset in the middle of a wait
    DREQ_M = 0; D_ACK = 0; DRW_M = 0; WEN_M = 0;
    repeat (3) @(posedge CLK);
    #2 RSTN = 0;
    #1;
    chk("mid_req_n", D_REQ_N, 1); chk("mid_stall", STALL_M, 0);
    chk("mid_wen", WEN_W, 1); chk("mid_err", ERR, 0);
    exp_err = 0;
    DREQ_M = 1;
    @(negedge CLK) RSTN = 1;
    @(posedge CLK); #1;
    run_op(0, 0, 1, 2'd0, 5'd12, 32'h0, 32'h5555, 32'h0, 32'h0, 0);
    for (int t = 0; t < 20; t++)
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 10));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
